// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - VGA raster timing types and default 640x480@60 constants
package vga_pkg;

   typedef struct packed {
      int visible;
      int front;
      int sync;
      int back;
   } axis_timing_t;

   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;

   localparam axis_timing_t DEF_H_TIMING = '{visible: DEF_H_VISIBLE, front: DEF_H_FRONT,
                                            sync: DEF_H_SYNC, back: DEF_H_BACK};
   localparam axis_timing_t DEF_V_TIMING = '{visible: DEF_V_VISIBLE, front: DEF_V_FRONT,
                                            sync: DEF_V_SYNC, back: DEF_V_BACK};

   function automatic int axisTotal(axis_timing_t t);
      return t.visible + t.front + t.sync + t.back;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - pixel bus between the timing generator and the pixel engine
interface pix_if #(
   parameter int H_CNT_WID = 10,
   parameter int V_CNT_WID = 10
);
   logic                 NEXT_FRAME;
   logic                 H_BLANKING;
   logic [H_CNT_WID-1:0] H_CNT;
   logic [V_CNT_WID-1:0] next_V_CNT;
   logic [3:0]           r;
   logic [3:0]           g;
   logic [3:0]           b;

   modport master (output NEXT_FRAME, H_BLANKING, H_CNT, next_V_CNT, input r, g, b);
   modport slave  (input NEXT_FRAME, H_BLANKING, H_CNT, next_V_CNT, output r, g, b);
endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping counter with blank and sync windows
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter axis_timing_t TIMING = DEF_H_TIMING,
   parameter int           WID    = 10
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   output logic [WID-1:0] count,
   output logic           wrap,
   output logic           blank,
   output logic           syncAct
);
   localparam int TOTAL = axisTotal(TIMING);

   localparam logic [WID-1:0] LAST       = WID'(TOTAL - 1);
   localparam logic [WID-1:0] VIS        = WID'(TIMING.visible);
   localparam logic [WID-1:0] SYNC_START = WID'(TIMING.visible + TIMING.front);
   localparam logic [WID-1:0] SYNC_END   = WID'(TIMING.visible + TIMING.front + TIMING.sync);

   if (TIMING.visible < 1 || TIMING.front < 1 || TIMING.sync < 1 || TIMING.back < 1) begin : gBadTiming
      $error("vga_axis_counter: visible, porch and sync widths must all be >= 1");
   end
   if (WID > 30 || TOTAL > (1 << WID)) begin : gBadWidth
      $error("vga_axis_counter: counter width too small for the axis total");
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (en) begin
         count <= wrap ? '0 : count + WID'(1);
      end
   end

   // Terminal count is independent of en so the V axis can be decoded mid-line.
   assign wrap    = (count == LAST);
   assign blank   = (count >= VIS);
   assign syncAct = (count >= SYNC_START) && (count < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing, pixel-bus requests and registered DAC outputs
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int   H_VISIBLE   = DEF_H_VISIBLE,
   parameter int   H_FRONT     = DEF_H_FRONT,
   parameter int   H_SYNC      = DEF_H_SYNC,
   parameter int   H_BACK      = DEF_H_BACK,
   parameter int   V_VISIBLE   = DEF_V_VISIBLE,
   parameter int   V_FRONT     = DEF_V_FRONT,
   parameter int   V_SYNC      = DEF_V_SYNC,
   parameter int   V_BACK      = DEF_V_BACK,
   parameter int   H_CNT_WID   = 10,
   parameter int   V_CNT_WID   = 10,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   pix_if.master      pixIf,
   output logic       vga_hsync,
   output logic       vga_vsync,
   output logic [3:0] vga_r,
   output logic [3:0] vga_g,
   output logic [3:0] vga_b
);
   localparam axis_timing_t H_TIMING = '{visible: H_VISIBLE, front: H_FRONT, sync: H_SYNC, back: H_BACK};
   localparam axis_timing_t V_TIMING = '{visible: V_VISIBLE, front: V_FRONT, sync: V_SYNC, back: V_BACK};
   localparam logic [V_CNT_WID-1:0] V_LAST_VIS = V_CNT_WID'(V_VISIBLE - 1);

   logic [H_CNT_WID-1:0] hCnt;
   logic [V_CNT_WID-1:0] vCnt;
   logic hWrap, hBlank, hsAct;
   logic vWrap, vBlank, vsAct;
   logic visible;

   vga_axis_counter #(.TIMING(H_TIMING), .WID(H_CNT_WID)) hCounter (
      .clk(clk), .rst(rst), .en(1'b1),
      .count(hCnt), .wrap(hWrap), .blank(hBlank), .syncAct(hsAct)
   );

   vga_axis_counter #(.TIMING(V_TIMING), .WID(V_CNT_WID)) vCounter (
      .clk(clk), .rst(rst), .en(hWrap),
      .count(vCnt), .wrap(vWrap), .blank(vBlank), .syncAct(vsAct)
   );

   // During h-blank the engine is already asked for the next line, so it can prefetch.
   assign pixIf.H_CNT      = hCnt;
   assign pixIf.H_BLANKING = hBlank;
   assign pixIf.next_V_CNT = !hBlank ? vCnt : (vWrap ? '0 : vCnt + V_CNT_WID'(1));
   assign pixIf.NEXT_FRAME = !rst && hWrap && (vCnt == V_LAST_VIS);

   assign visible = !hBlank && !vBlank;

   always_ff @(posedge clk) begin
      if (rst) begin
         vga_r     <= '0;
         vga_g     <= '0;
         vga_b     <= '0;
         vga_hsync <= !SYNC_ACTIVE;
         vga_vsync <= !SYNC_ACTIVE;
      end else begin
         vga_r     <= visible ? pixIf.r : '0;
         vga_g     <= visible ? pixIf.g : '0;
         vga_b     <= visible ? pixIf.b : '0;
         vga_hsync <= hsAct ? SYNC_ACTIVE : !SYNC_ACTIVE;
         vga_vsync <= vsAct ? SYNC_ACTIVE : !SYNC_ACTIVE;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen on a reduced raster
module tb_vga_timing_gen;
   localparam int HV = 16, HF = 2, HS = 4, HB = 3, HT = HV + HF + HS + HB;   // 25
   localparam int VV = 12, VF = 2, VS = 2, VB = 3, VT = VV + VF + VS + VB;   // 19
   localparam int FRAME = HT * VT;                                             // 475

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       hs, vs;
   logic [3:0] vr, vg, vb;

   int compared   = 0;
   int mismatched = 0;

   pix_if #(.H_CNT_WID(10), .V_CNT_WID(10)) pixIf ();

   vga_timing_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .H_CNT_WID(10), .V_CNT_WID(10), .SYNC_ACTIVE(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .pixIf(pixIf),
      .vga_hsync(hs), .vga_vsync(vs), .vga_r(vr), .vga_g(vg), .vga_b(vb)
   );

   // Combinational engine: r = line low nibble, g/b = H_CNT[7:4]/[3:0]
   assign pixIf.r = pixIf.next_V_CNT[3:0];
   assign pixIf.g = pixIf.H_CNT[7:4];
   assign pixIf.b = pixIf.H_CNT[3:0];

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: raster position is just the number of clocks since reset released
   int n = 0;
   bit pinsFromReset = 1'b1;
   bit modelLive = 1'b0;

   function automatic int hOf(input int k); return k % HT; endfunction
   function automatic int vOf(input int k); return (k / HT) % VT; endfunction
   function automatic int nextVOf(input int k);
      return (hOf(k) < HV) ? vOf(k) : (vOf(k) + 1) % VT;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         n <= 0;
         pinsFromReset <= 1'b1;
         modelLive <= 1'b1;
      end else begin
         n <= n + 1;
         pinsFromReset <= 1'b0;
      end
   end

   int  mh, mv, ph, pv, er, eg, eb, ehs, evs;
   bit  vis;
   always @(negedge clk) begin
      if (modelLive) begin
         mh = hOf(n);
         mv = vOf(n);
         check("H_CNT", int'(pixIf.H_CNT), mh);
         check("next_V_CNT", int'(pixIf.next_V_CNT), nextVOf(n));
         check("H_BLANKING", int'(pixIf.H_BLANKING), int'(mh >= HV));
         check("NEXT_FRAME", int'(pixIf.NEXT_FRAME), int'(mh == HT - 1 && mv == VV - 1));
         if (pinsFromReset) begin
            er = 0; eg = 0; eb = 0; ehs = 1; evs = 1;
         end else begin
            ph  = hOf(n - 1);
            pv  = vOf(n - 1);
            vis = (ph < HV) && (pv < VV);
            er  = vis ? nextVOf(n - 1) % 16 : 0;
            eg  = vis ? (ph / 16) % 16 : 0;
            eb  = vis ? ph % 16 : 0;
            ehs = (ph >= HV + HF && ph < HV + HF + HS) ? 0 : 1;
            evs = (pv >= VV + VF && pv < VV + VF + VS) ? 0 : 1;
         end
         check("vga_r", int'(vr), er);
         check("vga_g", int'(vg), eg);
         check("vga_b", int'(vb), eb);
         check("vga_hsync", int'(hs), ehs);
         check("vga_vsync", int'(vs), evs);
      end
   end

   task automatic waitAt(input int h, input int v);
      int guard = 0;
      while (!(hOf(n) == h && vOf(n) == v) && guard < 2 * FRAME) begin
         @(negedge clk);
         guard++;
      end
      check("waitAt_timeout", int'(guard >= 2 * FRAME), 0);
   endtask

   initial begin
      int  hsLow, vsLow, hsFirst, hsSecond, nfCount, nfFirst, nfGap, nfPrev, nfAfterRst;
      bit  prevHs;
      hsLow = 0; vsLow = 0; hsFirst = -1; hsSecond = -1;
      nfCount = 0; nfFirst = -1; nfGap = -1; nfPrev = -1; nfAfterRst = -1;
      prevHs = 1'b1;

      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_rgb", int'({vr, vg, vb}), 0);
      check("rst_hsync", int'(hs), 1);
      check("rst_vsync", int'(vs), 1);

      // Two full frames from raster start
      for (int c = 0; c < 2 * FRAME; c++) begin
         if (c < 3) check("count_up", int'(pixIf.H_CNT), c);
         if (c > 0) begin
            if (!hs) hsLow++;
            if (!vs) vsLow++;
            if (prevHs && !hs) begin
               if (hsFirst < 0) hsFirst = c;
               else if (hsSecond < 0) hsSecond = c;
            end
         end
         prevHs = hs;
         if (pixIf.NEXT_FRAME) begin
            nfCount++;
            if (nfFirst < 0) nfFirst = c;
            if (nfPrev >= 0) nfGap = c - nfPrev;
            nfPrev = c;
         end
         @(negedge clk);
      end
      check("hsync_low_cycles", hsLow, 152);
      check("hsync_first_fall", hsFirst, 19);
      check("hsync_second_fall", hsSecond, 44);
      check("vsync_low_cycles", vsLow, 100);
      check("next_frame_count", nfCount, 2);
      check("next_frame_first", nfFirst, 299);
      check("next_frame_gap", nfGap, 475);

      waitAt(5, 3);
      @(negedge clk);
      check("pix_5_3_r", int'(vr), 3);
      check("pix_5_3_g", int'(vg), 0);
      check("pix_5_3_b", int'(vb), 5);

      waitAt(15, 10);
      check("nextV_15_10", int'(pixIf.next_V_CNT), 10);
      check("hblank_15", int'(pixIf.H_BLANKING), 0);
      waitAt(16, 10);
      check("nextV_16_10", int'(pixIf.next_V_CNT), 11);
      check("hblank_16", int'(pixIf.H_BLANKING), 1);
      waitAt(20, 18);
      check("nextV_20_18", int'(pixIf.next_V_CNT), 0);

      // Mid-frame reset
      waitAt(12, 7);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mrst_H_CNT", int'(pixIf.H_CNT), 0);
      check("mrst_nextV", int'(pixIf.next_V_CNT), 0);
      check("mrst_rgb", int'({vr, vg, vb}), 0);
      check("mrst_hsync", int'(hs), 1);
      check("mrst_vsync", int'(vs), 1);
      for (int k = 0; k < 600; k++) begin
         if (pixIf.NEXT_FRAME) begin
            nfAfterRst = k;
            break;
         end
         @(negedge clk);
      end
      check("mrst_next_frame_at", nfAfterRst, 299);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
